elevator_dispatcher: RTL and testbench

Consumer end of the floor-request queue: reads the queue head, moves the car one floor at a time toward it, opens the door for a fixed time, then pops the served entry with a one-cycle shift pulse. Sits between the request queue RAM (its `addr`/`q`/`shift` ports) and the car motor/door drivers and displays. The producer side (call buttons using `weT`) is out of scope.

---
 rtl/elevator_dispatcher_pkg.sv | 30 +++
 rtl/elevator_dispatcher_if.sv | 36 +++
 rtl/elevator_dispatcher_timer.sv | 33 +++
 rtl/elevator_dispatcher.sv | 171 +++++++++++++++++
 tb/tb_elevator_dispatcher.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/elevator_dispatcher_pkg.sv
// ============================================================================
// elevator_pkg : shared encodings and constants for the elevator dispatcher
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

package elevator_pkg;

  localparam int FLOOR_W = 4;

  localparam logic [FLOOR_W-1:0] EMPTY_SLOT   = 4'd0;
  localparam logic [FLOOR_W-1:0] GROUND_FLOOR = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOVE   = 3'd1,
    ST_DOOR   = 3'd2,
    ST_POP    = 3'd3,
    ST_SETTLE = 3'd4
  } state_t;

  // One floor toward the target; callers guarantee the result stays in range.
  function automatic logic [FLOOR_W-1:0] step_floor(input logic [FLOOR_W-1:0] floor,
                                                    input logic              up);
    return up ? (floor + 4'd1) : (floor - 4'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_dispatcher_if.sv
// ============================================================================
// elevator_dispatcher_if : queue-read port plus car command/status bundle
// Revision               : 1.0 - initial release
// ============================================================================
`default_nettype none

interface elevator_dispatcher_if;
  import elevator_pkg::*;

  logic [FLOOR_W-1:0] q_addr;
  logic [FLOOR_W-1:0] q_data;
  logic               q_shift;
  logic [FLOOR_W-1:0] current_floor;
  logic [FLOOR_W-1:0] target_floor;
  logic               move_up;
  logic               move_down;
  logic               door_open;
  logic               busy;
  logic               served;
  logic               bad_req;

  modport master (
    output q_addr, q_shift, current_floor, target_floor,
           move_up, move_down, door_open, busy, served, bad_req,
    input  q_data
  );

  modport slave (
    input  q_addr, q_shift, current_floor, target_floor,
           move_up, move_down, door_open, busy, served, bad_req,
    output q_data
  );

endinterface

`default_nettype wire

// File: rtl/elevator_dispatcher_timer.sv
// ============================================================================
// dispatch_timer : loadable down-counter, expired while the count sits at zero
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch_timer #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_load,
  input  wire logic [CNT_W-1:0] i_load_value,
  output logic                  o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/elevator_dispatcher.sv
// ============================================================================
// elevator_dispatcher : serves the request-queue head one floor at a time
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int MOVE_CYCLES = 50,
  parameter int DOOR_CYCLES = 100,
  parameter int NUM_FLOORS  = 15
) (
  input  wire logic              clk,
  input  wire logic              reset,
  elevator_dispatcher_if.master  bus
);

  localparam int c_MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

  // Loading N-1 gives exactly N cycles until the counter reads zero.
  localparam logic [c_CNT_W-1:0] c_MOVE_LOAD = c_CNT_W'(MOVE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DOOR_LOAD = c_CNT_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] c_TOP_FLOOR = FLOOR_W'(NUM_FLOORS);

  state_t             r_state;
  logic [FLOOR_W-1:0] r_floor;
  logic [FLOOR_W-1:0] r_target;
  logic               r_move_up;
  logic               r_move_down;
  logic               r_door;
  logic               r_busy;
  logic               r_shift;
  logic               r_served;
  logic               r_bad_req;

  logic               w_head_empty;
  logic               w_head_bad;
  logic               w_head_here;
  logic [FLOOR_W-1:0] w_next_floor;
  logic               w_arrive;
  logic               w_expired;
  logic               w_load;
  logic [c_CNT_W-1:0] w_load_value;

  assign w_head_empty = (bus.q_data == EMPTY_SLOT);
  assign w_head_bad   = (bus.q_data > c_TOP_FLOOR);
  assign w_head_here  = (bus.q_data == r_floor);
  assign w_next_floor = step_floor(r_floor, r_move_up);
  assign w_arrive     = (w_next_floor == r_target);

  always_comb begin
    w_load       = 1'b0;
    w_load_value = c_MOVE_LOAD;
    case (r_state)
      ST_IDLE: begin
        if (!w_head_empty && !w_head_bad) begin
          w_load       = 1'b1;
          w_load_value = w_head_here ? c_DOOR_LOAD : c_MOVE_LOAD;
        end
      end
      ST_MOVE: begin
        if (w_expired) begin
          w_load       = 1'b1;
          w_load_value = w_arrive ? c_DOOR_LOAD : c_MOVE_LOAD;
        end
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  dispatch_timer #(
    .CNT_W (c_CNT_W)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .o_expired    (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_floor     <= GROUND_FLOOR;
      r_target    <= EMPTY_SLOT;
      r_move_up   <= 1'b0;
      r_move_down <= 1'b0;
      r_door      <= 1'b0;
      r_busy      <= 1'b0;
      r_shift     <= 1'b0;
      r_served    <= 1'b0;
      r_bad_req   <= 1'b0;
    end else begin
      r_shift   <= 1'b0;
      r_served  <= 1'b0;
      r_bad_req <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_head_bad) begin
            r_state   <= ST_POP;
            r_busy    <= 1'b1;
            r_shift   <= 1'b1;
            r_bad_req <= 1'b1;
          end else if (!w_head_empty) begin
            r_target <= bus.q_data;
            r_busy   <= 1'b1;
            if (w_head_here) begin
              r_state <= ST_DOOR;
              r_door  <= 1'b1;
            end else begin
              r_state     <= ST_MOVE;
              r_move_up   <= (bus.q_data > r_floor);
              r_move_down <= (bus.q_data < r_floor);
            end
          end
        end
        ST_MOVE: begin
          if (w_expired) begin
            r_floor <= w_next_floor;
            if (w_arrive) begin
              r_state     <= ST_DOOR;
              r_move_up   <= 1'b0;
              r_move_down <= 1'b0;
              r_door      <= 1'b1;
            end
          end
        end
        ST_DOOR: begin
          if (w_expired) begin
            r_state  <= ST_POP;
            r_door   <= 1'b0;
            r_shift  <= 1'b1;
            r_served <= 1'b1;
          end
        end
        ST_POP: begin
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_move_up   <= 1'b0;
          r_move_down <= 1'b0;
          r_door      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q_addr        = EMPTY_SLOT;
  assign bus.q_shift       = r_shift;
  assign bus.current_floor = r_floor;
  assign bus.target_floor  = r_target;
  assign bus.move_up       = r_move_up;
  assign bus.move_down     = r_move_down;
  assign bus.door_open     = r_door;
  assign bus.busy          = r_busy;
  assign bus.served        = r_served;
  assign bus.bad_req       = r_bad_req;

endmodule

`default_nettype wire

// File: tb/tb_elevator_dispatcher.sv
// ============================================================================
// tb_elevator_dispatcher : directed scenarios against a shifting queue model
// Revision               : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_elevator_dispatcher;

  logic clk;
  logic reset;

  elevator_dispatcher_if bus();

  elevator_dispatcher #(
    .MOVE_CYCLES (4),
    .DOOR_CYCLES (6),
    .NUM_FLOORS  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue RAM model: registered read address, whole-queue shift on pop.
  logic [3:0] ram    [16];
  logic [3:0] preset [16];
  logic       preset_req;
  logic [3:0] addr_reg;

  always @(posedge clk) begin
    addr_reg <= bus.q_addr;
    if (preset_req) begin
      for (int i = 0; i < 16; i++) ram[i] <= preset[i];
    end else if (bus.q_shift) begin
      for (int i = 0; i < 15; i++) ram[i] <= ram[i+1];
      ram[15] <= 4'd0;
    end
  end

  assign bus.q_data = ram[addr_reg];

  int total = 0;
  int bad   = 0;

  int n_up, n_down, n_both, n_door, n_shift, n_served, n_bad, n_busy;
  int n_shift_bad, n_shift_served, cyc, last_shift, min_gap;
  logic [3:0] prev_floor;
  logic [3:0] floor_log[$];

  task automatic clear_counts();
    n_up = 0; n_down = 0; n_both = 0; n_door = 0; n_shift = 0;
    n_served = 0; n_bad = 0; n_busy = 0; n_shift_bad = 0; n_shift_served = 0;
    cyc = 0; last_shift = -1; min_gap = 1000;
    floor_log.delete();
    prev_floor = bus.current_floor;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.move_up)   n_up++;
      if (bus.move_down) n_down++;
      if (bus.move_up && bus.move_down) n_both++;
      if (bus.door_open) n_door++;
      if (bus.served)    n_served++;
      if (bus.bad_req)   n_bad++;
      if (bus.busy)      n_busy++;
      if (bus.q_shift && bus.bad_req) n_shift_bad++;
      if (bus.q_shift && bus.served)  n_shift_served++;
      if (bus.q_shift) begin
        n_shift++;
        if (last_shift >= 0 && (cyc - last_shift) < min_gap) min_gap = cyc - last_shift;
        last_shift = cyc;
      end
      if (bus.current_floor !== prev_floor) begin
        floor_log.push_back(bus.current_floor);
        prev_floor = bus.current_floor;
      end
    end
  endtask

  task automatic load_and_reset(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    for (int i = 0; i < 16; i++) preset[i] = 4'd0;
    preset[0] = a; preset[1] = b; preset[2] = c;
    @(negedge clk);
    reset = 1'b1;
    preset_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    preset_req = 1'b0;
    reset = 1'b0;
    clear_counts();
  endtask

  task automatic test_reset();
    load_and_reset(4'd0, 4'd0, 4'd0);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.current_floor !== 4'd1) begin bad++; $display("FAIL reset_floor got=%0d want=1", bus.current_floor); end
    total++; if (bus.target_floor !== 4'd0) begin bad++; $display("FAIL reset_target got=%0d want=0", bus.target_floor); end
    total++; if ({bus.move_up, bus.move_down, bus.door_open} !== 3'b000) begin bad++; $display("FAIL reset_motor_door got=%b want=000", {bus.move_up, bus.move_down, bus.door_open}); end
    total++; if ({bus.q_shift, bus.served, bus.bad_req} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {bus.q_shift, bus.served, bus.bad_req}); end
    total++; if (bus.q_addr !== 4'd0) begin bad++; $display("FAIL reset_qaddr got=%0d want=0", bus.q_addr); end
  endtask

  task automatic test_empty();
    load_and_reset(4'd0, 4'd0, 4'd0);
    run_cycles(200);
    total++; if (n_busy !== 0) begin bad++; $display("FAIL empty_busy got=%0d want=0", n_busy); end
    total++; if (n_shift !== 0) begin bad++; $display("FAIL empty_shift got=%0d want=0", n_shift); end
    total++; if (bus.current_floor !== 4'd1) begin bad++; $display("FAIL empty_floor got=%0d want=1", bus.current_floor); end
  endtask

  task automatic test_up_four();
    logic [3:0] exp_floors [3];
    exp_floors[0] = 4'd2; exp_floors[1] = 4'd3; exp_floors[2] = 4'd4;
    load_and_reset(4'd4, 4'd0, 4'd0);
    run_cycles(40);
    total++; if (n_up !== 12) begin bad++; $display("FAIL up4_move_up got=%0d want=12", n_up); end
    total++; if (n_down !== 0) begin bad++; $display("FAIL up4_move_down got=%0d want=0", n_down); end
    total++; if (n_door !== 6) begin bad++; $display("FAIL up4_door got=%0d want=6", n_door); end
    total++; if (n_shift_served !== 1 || n_shift !== 1 || n_served !== 1) begin bad++; $display("FAIL up4_pop got=%0d/%0d/%0d want=1/1/1", n_shift, n_served, n_shift_served); end
    total++; if (n_busy !== 20) begin bad++; $display("FAIL up4_busy_cycles got=%0d want=20", n_busy); end
    total++; if (floor_log.size() !== 3) begin bad++; $display("FAIL up4_floor_steps got=%0d want=3", floor_log.size()); end
    for (int i = 0; i < 3 && i < floor_log.size(); i++) begin
      total++; if (floor_log[i] !== exp_floors[i]) begin bad++; $display("FAIL up4_floor_seq[%0d] got=%0d want=%0d", i, floor_log[i], exp_floors[i]); end
    end
    total++; if (bus.target_floor !== 4'd4) begin bad++; $display("FAIL up4_target got=%0d want=4", bus.target_floor); end
  endtask

  task automatic test_same_floor();
    load_and_reset(4'd1, 4'd0, 4'd0);
    run_cycles(30);
    total++; if (n_up + n_down !== 0) begin bad++; $display("FAIL same_motion got=%0d want=0", n_up + n_down); end
    total++; if (n_door !== 6) begin bad++; $display("FAIL same_door got=%0d want=6", n_door); end
    total++; if (n_shift !== 1 || n_served !== 1) begin bad++; $display("FAIL same_pop got=%0d/%0d want=1/1", n_shift, n_served); end
    total++; if (n_busy !== 8) begin bad++; $display("FAIL same_busy_cycles got=%0d want=8", n_busy); end
  endtask

  task automatic test_back_to_back();
    load_and_reset(4'd6, 4'd2, 4'd0);
    run_cycles(100);
    total++; if (n_up !== 20) begin bad++; $display("FAIL b2b_move_up got=%0d want=20", n_up); end
    total++; if (n_down !== 16) begin bad++; $display("FAIL b2b_move_down got=%0d want=16", n_down); end
    total++; if (n_both !== 0) begin bad++; $display("FAIL b2b_both_motors got=%0d want=0", n_both); end
    total++; if (n_door !== 12) begin bad++; $display("FAIL b2b_door got=%0d want=12", n_door); end
    total++; if (n_shift !== 2 || n_served !== 2) begin bad++; $display("FAIL b2b_pops got=%0d/%0d want=2/2", n_shift, n_served); end
    total++; if (min_gap < 3) begin bad++; $display("FAIL b2b_pop_gap got=%0d want>=3", min_gap); end
    total++; if (n_busy !== 52) begin bad++; $display("FAIL b2b_busy_cycles got=%0d want=52", n_busy); end
    total++; if (bus.current_floor !== 4'd2 || bus.target_floor !== 4'd2) begin bad++; $display("FAIL b2b_final got=%0d/%0d want=2/2", bus.current_floor, bus.target_floor); end
  endtask

  task automatic test_bad_req();
    load_and_reset(4'd15, 4'd0, 4'd0);
    run_cycles(20);
    total++; if (n_shift_bad !== 1 || n_bad !== 1 || n_shift !== 1) begin bad++; $display("FAIL bad_pulse got=%0d/%0d/%0d want=1/1/1", n_shift, n_bad, n_shift_bad); end
    total++; if (n_served !== 0) begin bad++; $display("FAIL bad_served got=%0d want=0", n_served); end
    total++; if (n_up + n_down + n_door !== 0) begin bad++; $display("FAIL bad_activity got=%0d want=0", n_up + n_down + n_door); end
    total++; if (n_busy !== 2) begin bad++; $display("FAIL bad_busy_cycles got=%0d want=2", n_busy); end
    total++; if (bus.target_floor !== 4'd0 || bus.current_floor !== 4'd1) begin bad++; $display("FAIL bad_regs got=%0d/%0d want=0/1", bus.target_floor, bus.current_floor); end
  endtask

  task automatic test_reset_mid();
    int waited;
    load_and_reset(4'd5, 4'd0, 4'd0);
    waited = 0;
    while (bus.current_floor !== 4'd3 && waited < 100) begin
      run_cycles(1);
      waited++;
    end
    total++; if (waited >= 100) begin bad++; $display("FAIL mid_reach_floor3 got=%0d want=3", bus.current_floor); end
    total++; if (n_shift !== 0) begin bad++; $display("FAIL mid_early_pop got=%0d want=0", n_shift); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.current_floor !== 4'd1) begin bad++; $display("FAIL mid_floor got=%0d want=1", bus.current_floor); end
    total++; if ({bus.busy, bus.move_up, bus.move_down, bus.door_open, bus.q_shift} !== 5'b0) begin bad++; $display("FAIL mid_outputs got=%b want=00000", {bus.busy, bus.move_up, bus.move_down, bus.door_open, bus.q_shift}); end
    total++; if (bus.target_floor !== 4'd0) begin bad++; $display("FAIL mid_target got=%0d want=0", bus.target_floor); end
    reset = 1'b0;
    clear_counts();
    run_cycles(60);
    total++; if (n_up !== 16) begin bad++; $display("FAIL mid_retravel got=%0d want=16", n_up); end
    total++; if (n_shift !== 1 || n_served !== 1) begin bad++; $display("FAIL mid_pop got=%0d/%0d want=1/1", n_shift, n_served); end
    total++; if (bus.current_floor !== 4'd5) begin bad++; $display("FAIL mid_final_floor got=%0d want=5", bus.current_floor); end
  endtask

  initial begin
    reset = 1'b1;
    preset_req = 1'b0;
    addr_reg = 4'd0;
    for (int i = 0; i < 16; i++) begin
      preset[i] = 4'd0;
      ram[i] = 4'd0;
    end
    clear_counts();
    test_reset();
    test_empty();
    test_up_four();
    test_same_floor();
    test_back_to_back();
    test_bad_req();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
